hdc_bundler: RTL and testbench
==============================

// Module: hdc_bundler
// PURPOSE
//  Bundles one hypervector dimension in the sparse-HDC encoder. Popcounts a FEATURE_COUNT-bit
//  vector: one bit per feature for the same dimension. Compares the count to THRESHOLD and
//  emits one thresholded bit plus a done pulse. Sits between the feature-binding stage and
//  the sample hypervector register.
//  Processes CHUNK_W bits per cycle to bound adder depth.
// PARAMETERS
//  FEATURE_COUNT  40  width of bits_to_bundle (number of bound feature bits)
//  CHUNK_W         8  bits popcounted per cycle; NCHUNK = ceil(FEATURE_COUNT/CHUNK_W)
//  THRESHOLD      20  thresholded_bit = 1 iff popcount >= THRESHOLD
// PORTS
//  clk              in   1              single clock, all logic on rising edge
//  nrst             in   1              reset; synchronous and active-high (asserted = 1)
//  en               in   1              clock enable; 0 freezes all state and outputs
//  start_bundling   in   1              level request; sampled in IDLE
//  bits_to_bundle   in   FEATURE_COUNT  vector to bundle; latched when start is accepted
//  bundling_done    out  1              registered, 1-cycle pulse; result valid
//  thresholded_bit  out  1              registered result; held until next result
// BEHAVIOUR
//  Reset (nrst=1 at a clk edge): go to IDLE.
//   - bundling_done=0, thresholded_bit=0.
//   - Accumulator, chunk index and latched vector cleared.
//   - Reset overrides en and aborts any operation in progress; no done pulse follows.
//  en=0: no state, counter or output register changes (full stall, including mid-ACCUM).
//  FSM states: IDLE -> ACCUM -> DONE -> RELEASE -> IDLE. All transitions require en=1.
//  IDLE:
//   - On edge with start_bundling=1: latch bits_to_bundle, set acc=0 and idx=0, go to ACCUM.
//  ACCUM (one chunk per edge):
//   - acc += popcount(vec[idx*CHUNK_W +: CHUNK_W]), then idx++.
//   - Bits above FEATURE_COUNT-1 in the last chunk are treated as 0.
//   - After chunk NCHUNK-1 is added, go to DONE.
//  DONE (one edge): thresholded_bit <= (acc >= THRESHOLD); bundling_done <= 1.
//   - If start_bundling=1, go to RELEASE; otherwise go straight to IDLE.
//  RELEASE: bundling_done <= 0; wait for start_bundling=0, then go to IDLE.
//   - A held start level does not retrigger.
//  bundling_done is high for exactly one enabled cycle per accepted start.
//  Latency: start accepted at edge k.
//   - Chunks are added at edges k+1..k+NCHUNK.
//   - bundling_done and the new thresholded_bit become visible after edge k+NCHUNK+1.
//   - Defaults: NCHUNK=5, so the result is visible 6 edges after acceptance.
//  Start while in ACCUM, DONE or RELEASE is ignored. Changes to bits_to_bundle after latching are ignored.
//  acc width = $clog2(FEATURE_COUNT+1), unsigned; no overflow possible.
//  Count == THRESHOLD gives 1. All-zero vector gives 0 (THRESHOLD>0).
//  thresholded_bit is stable between done pulses.
// TESTING
//  1. Hold reset 1 cycle with en=1 -> bundling_done=0, thresholded_bit=0. No activity while start=0.
//  2. en=1, vec=40'hF5AC39B72F, start held 10 cycles.
//     -> popcount 25, thresholded_bit=1.
//     -> done pulses once, 6 edges after acceptance; no retrigger while start remains high.
//  3. vec=40'h00000FFFFF (count 20), then 40'h000007FFFF (count 19).
//     -> thresholded_bit=1, then 0; boundary at THRESHOLD.
//  4. Drop en for 3 cycles mid-ACCUM with vec=40'hFFFFFFFFFF.
//     -> done is delayed by exactly 3 cycles; thresholded_bit=1 (count 40).
//  5. Assert reset 2 cycles into ACCUM -> no done pulse, outputs 0, FSM in IDLE.
//     A new start then works normally.
//  6. Change bits_to_bundle to 0 during ACCUM after starting with 40'hFFFFFFFFFF.
//     -> result still 1, computed from the latched value.

Source files
------------

// File: rtl/hdc_bundler.sv
// hdc_bundler: bundles one hypervector dimension of the sparse-HDC encoder.
// A FEATURE_COUNT-bit vector (one bound bit per feature) is latched on start,
// popcounted CHUNK_W bits per enabled cycle, and compared against THRESHOLD.
// The thresholded bit is published together with a one-cycle done pulse.
//
// Ports
//   clk              clock, all logic on the rising edge
//   nrst             synchronous reset, active-high (overrides en)
//   en               clock enable; 0 freezes every register
//   start_bundling   level request, sampled only in IDLE
//   bits_to_bundle   vector to bundle, latched when start is accepted
//   bundling_done    registered one-cycle pulse, result valid
//   thresholded_bit  registered result, held until the next result
module hdc_bundler #(
   parameter int unsigned FEATURE_COUNT = 40,
   parameter int unsigned CHUNK_W       = 8,
   parameter int unsigned THRESHOLD     = 20
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     en,
   input  logic                     start_bundling,
   input  logic [FEATURE_COUNT-1:0] bits_to_bundle,
   output logic                     bundling_done,
   output logic                     thresholded_bit
);

   localparam int unsigned NCHUNK = (FEATURE_COUNT + CHUNK_W - 1) / CHUNK_W;
   // Latched vector is zero-padded to whole chunks so the last chunk reads 0s.
   localparam int unsigned PAD_W  = NCHUNK * CHUNK_W;
   localparam int unsigned ACC_W  = $clog2(FEATURE_COUNT + 1);
   localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCUM   = 2'd1,
      S_DONE    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [PAD_W-1:0]   vec_q, vec_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               done_q, done_d;
   logic               bit_q, bit_d;

   logic [CHUNK_W-1:0] chunk_c;
   logic [ACC_W-1:0]   chunk_cnt_c;

   // Current chunk selected by shifting, which keeps the select width-clean.
   assign chunk_c = CHUNK_W'(vec_q >> (32'(idx_q) * CHUNK_W));

   // Popcount of one chunk; padding guarantees it fits in ACC_W.
   always_comb begin
      chunk_cnt_c = '0;
      for (int i = 0; i < int'(CHUNK_W); i++) begin
         chunk_cnt_c = chunk_cnt_c + ACC_W'(chunk_c[i]);
      end
   end

   // Next-state and next-register logic.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      bit_d   = bit_q;
      case (state_q)
         S_IDLE: begin
            if (start_bundling) begin
               vec_d   = PAD_W'(bits_to_bundle);
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            acc_d = acc_q + chunk_cnt_c;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_DONE: begin
            bit_d   = (32'(acc_q) >= THRESHOLD);
            done_d  = 1'b1;
            // A still-high start must drop before another request is taken.
            state_d = start_bundling ? S_RELEASE : S_IDLE;
         end
         S_RELEASE: begin
            if (!start_bundling) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset wins over the enable.
   always_ff @(posedge clk) begin
      if (nrst) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         bit_q   <= 1'b0;
      end else if (en) begin
         state_q <= state_d;
         vec_q   <= vec_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         bit_q   <= bit_d;
      end
   end

   assign bundling_done   = done_q;
   assign thresholded_bit = bit_q;

endmodule

// File: tb/tb_hdc_bundler.sv
module tb_hdc_bundler;

   localparam int FC   = 40;
   localparam int CW   = 8;
   localparam int THR  = 20;
   localparam int NCH  = (FC + CW - 1) / CW;
   localparam int LAT  = NCH + 1;

   logic          clk;
   logic          nrst;
   logic          en;
   logic          start_bundling;
   logic [FC-1:0] bits_to_bundle;
   logic          bundling_done;
   logic          thresholded_bit;

   int total;
   int bad;
   bit exp_bit;

   hdc_bundler #(.FEATURE_COUNT(FC), .CHUNK_W(CW), .THRESHOLD(THR)) dut (
      .clk             (clk),
      .nrst            (nrst),
      .en              (en),
      .start_bundling  (start_bundling),
      .bits_to_bundle  (bits_to_bundle),
      .bundling_done   (bundling_done),
      .thresholded_bit (thresholded_bit)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain popcount against the threshold.
   function automatic bit model(input logic [FC-1:0] v);
      return $countones(v) >= THR;
   endfunction

   function automatic logic [FC-1:0] rand_vec();
      logic [63:0] a;
      logic [63:0] b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom % 3)
         0: return FC'(a & b);
         1: return FC'(a | b);
         default: return FC'(a);
      endcase
   endfunction

   task automatic test_reset();
      nrst = 1'b1; en = 1'b1; start_bundling = 1'b0;
      bits_to_bundle = rand_vec();
      tick();
      total++;
      if (bundling_done !== 1'b0) begin
         bad++; $display("FAIL reset_done: got %b want 0", bundling_done);
      end
      total++;
      if (thresholded_bit !== 1'b0) begin
         bad++; $display("FAIL reset_bit: got %b want 0", thresholded_bit);
      end
      nrst = 1'b0;
      for (int n = 0; n < 6; n++) begin
         tick();
         total++;
         if (bundling_done !== 1'b0 || thresholded_bit !== 1'b0) begin
            bad++;
            $display("FAIL idle_quiet: got done=%b bit=%b want 0 0", bundling_done, thresholded_bit);
         end
      end
      exp_bit = 1'b0;
   endtask

   task automatic test_held_start();
      logic [FC-1:0] v;
      int pulses;
      int first;
      v = 40'hF5AC39B72F;
      pulses = 0; first = -1;
      bits_to_bundle = v; start_bundling = 1'b1;
      tick();
      for (int n = 1; n <= 12; n++) begin
         tick();
         if (bundling_done === 1'b1) begin
            pulses++;
            if (first < 0) first = n;
         end
      end
      start_bundling = 1'b0;
      for (int n = 0; n < 4; n++) begin
         tick();
         if (bundling_done === 1'b1) pulses++;
      end
      total++;
      if (first != LAT) begin
         bad++; $display("FAIL held_latency: got %0d want %0d", first, LAT);
      end
      total++;
      if (pulses != 1) begin
         bad++; $display("FAIL held_pulses: got %0d want 1", pulses);
      end
      total++;
      if (thresholded_bit !== model(v)) begin
         bad++; $display("FAIL held_bit: got %b want %b", thresholded_bit, model(v));
      end
      exp_bit = model(v);
   endtask

   task automatic test_threshold();
      logic [FC-1:0] vs [2];
      vs[0] = 40'h00000FFFFF;
      vs[1] = 40'h000007FFFF;
      for (int t = 0; t < 2; t++) begin
         int lat;
         lat = -1;
         bits_to_bundle = vs[t]; start_bundling = 1'b1;
         tick();
         start_bundling = 1'b0;
         for (int n = 1; n <= 20 && lat < 0; n++) begin
            tick();
            if (bundling_done === 1'b1) begin
               lat = n;
            end else begin
               total++;
               if (thresholded_bit !== exp_bit) begin
                  bad++; $display("FAIL thr_stable: got %b want %b", thresholded_bit, exp_bit);
               end
            end
         end
         total++;
         if (lat != LAT) begin
            bad++; $display("FAIL thr_latency: got %0d want %0d", lat, LAT);
         end
         total++;
         if (thresholded_bit !== model(vs[t])) begin
            bad++; $display("FAIL thr_bit%0d: got %b want %b", t, thresholded_bit, model(vs[t]));
         end
         exp_bit = model(vs[t]);
         tick(); tick();
      end
   endtask

   task automatic test_en_stall();
      int lat;
      lat = -1;
      bits_to_bundle = '1; start_bundling = 1'b1;
      tick();
      start_bundling = 1'b0;
      tick(); tick();
      en = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         total++;
         if (bundling_done !== 1'b0) begin
            bad++; $display("FAIL stall_done: got %b want 0", bundling_done);
         end
      end
      en = 1'b1;
      for (int n = 6; n <= 30 && lat < 0; n++) begin
         tick();
         if (bundling_done === 1'b1) lat = n;
      end
      total++;
      if (lat != LAT + 3) begin
         bad++; $display("FAIL stall_latency: got %0d want %0d", lat, LAT + 3);
      end
      total++;
      if (thresholded_bit !== 1'b1) begin
         bad++; $display("FAIL stall_bit: got %b want 1", thresholded_bit);
      end
      exp_bit = 1'b1;
      tick(); tick();
   endtask

   task automatic test_reset_abort();
      int pulses;
      int lat;
      pulses = 0; lat = -1;
      bits_to_bundle = '1; start_bundling = 1'b1;
      tick();
      start_bundling = 1'b0;
      tick(); tick();
      nrst = 1'b1;
      tick();
      nrst = 1'b0;
      total++;
      if (bundling_done !== 1'b0 || thresholded_bit !== 1'b0) begin
         bad++;
         $display("FAIL abort_outputs: got done=%b bit=%b want 0 0", bundling_done, thresholded_bit);
      end
      for (int n = 0; n < 10; n++) begin
         tick();
         if (bundling_done === 1'b1) pulses++;
      end
      total++;
      if (pulses != 0) begin
         bad++; $display("FAIL abort_pulses: got %0d want 0", pulses);
      end
      exp_bit = 1'b0;
      bits_to_bundle = 40'h00000FFFFF; start_bundling = 1'b1;
      tick();
      start_bundling = 1'b0;
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         tick();
         if (bundling_done === 1'b1) lat = n;
      end
      total++;
      if (lat != LAT) begin
         bad++; $display("FAIL abort_restart_latency: got %0d want %0d", lat, LAT);
      end
      total++;
      if (thresholded_bit !== 1'b1) begin
         bad++; $display("FAIL abort_restart_bit: got %b want 1", thresholded_bit);
      end
      exp_bit = 1'b1;
      tick(); tick();
   endtask

   task automatic test_latched();
      int lat;
      lat = -1;
      // Clear the result first so a correct 1 is not merely a held value.
      bits_to_bundle = '0; start_bundling = 1'b1;
      tick();
      start_bundling = 1'b0;
      for (int n = 0; n < LAT + 2; n++) tick();
      total++;
      if (thresholded_bit !== 1'b0) begin
         bad++; $display("FAIL latch_zero: got %b want 0", thresholded_bit);
      end
      bits_to_bundle = '1; start_bundling = 1'b1;
      tick();
      bits_to_bundle = '0; start_bundling = 1'b0;
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         tick();
         if (bundling_done === 1'b1) lat = n;
      end
      total++;
      if (lat != LAT || thresholded_bit !== 1'b1) begin
         bad++; $display("FAIL latch_bit: got lat=%0d bit=%b want lat=%0d bit=1", lat, thresholded_bit, LAT);
      end
      exp_bit = 1'b1;
      tick(); tick();
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         logic [FC-1:0] v;
         bit exp;
         int enabled;
         bit seen;
         en = 1'b1; start_bundling = 1'b0;
         tick(); tick();
         v = rand_vec();
         exp = model(v);
         bits_to_bundle = v; start_bundling = 1'b1;
         tick();
         enabled = 0; seen = 1'b0;
         for (int n = 0; n < 200 && !seen; n++) begin
            logic en_now;
            en_now = ($urandom % 4) != 0;
            en = en_now;
            start_bundling = 1'($urandom % 2);
            bits_to_bundle = rand_vec();
            tick();
            if (en_now) enabled++;
            if (bundling_done === 1'b1) begin
               seen = 1'b1;
            end else begin
               total++;
               if (thresholded_bit !== exp_bit || enabled >= LAT) begin
                  bad++;
                  $display("FAIL rand_wait%0d: got bit=%b en_edges=%0d want bit=%b en_edges<%0d",
                           it, thresholded_bit, enabled, exp_bit, LAT);
               end
            end
         end
         total++;
         if (!seen) begin
            bad++; $display("FAIL rand_timeout%0d: got no done want done", it);
         end else begin
            if (enabled != LAT || thresholded_bit !== exp) begin
               bad++;
               $display("FAIL rand_result%0d: got en_edges=%0d bit=%b want en_edges=%0d bit=%b",
                        it, enabled, thresholded_bit, LAT, exp);
            end
         end
         exp_bit = exp;
         en = 1'b1; start_bundling = 1'b0;
         tick();
         total++;
         if (bundling_done !== 1'b0) begin
            bad++; $display("FAIL rand_pulse_width%0d: got %b want 0", it, bundling_done);
         end
      end
   endtask

   initial begin
      total = 0; bad = 0; exp_bit = 1'b0;
      nrst = 1'b1; en = 1'b1; start_bundling = 1'b0; bits_to_bundle = '0;
      test_reset();
      test_held_start();
      test_threshold();
      test_en_stall();
      test_reset_abort();
      test_latched();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
